idelay_cal_seq: RTL and testbench
=================================

Name: idelay_cal_seq

Overview:
- Sequences the IDELAYCTRL reset/ready handshake in the board infrastructure.
- After system reset it drives the IDELAYCTRL reset pulse, waits for a qualified ready, and retries on timeout.
- It also watches for loss of ready, recalibrates automatically, and reports status to the rest of the BSP.
- Runs entirely in the sys_clk domain; idelay_rdy (REFCLK domain) is synchronised internally.

Parameters:
RST_CYCLES, 16, cycles idelay_rst is held high per attempt; must be >= SYNC_STAGES+2
TIMEOUT_CYCLES, 4096, max cycles in WAIT_RDY per attempt before timeout
MAX_RETRIES, 3, extra attempts after the first (total attempts = MAX_RETRIES+1); range 0..15
RDY_STABLE, 4, consecutive synchronised-high cycles needed to accept ready
SYNC_STAGES, 2, flops in the idelay_rdy synchroniser (>= 2)

Ports:
sys_clk  in  1  sole clock
sys_rst  in  1  synchronous, active-high reset
start  in  1  single-cycle recalibration request
status_clear  in  1  single-cycle clear of lost_count
idelay_rdy  in  1  IDELAYCTRL RDY, asynchronous to sys_clk
idelay_rst  out  1  IDELAYCTRL RST
cal_busy  out  1  high in ASSERT_RST or WAIT_RDY
cal_done  out  1  high in READY
cal_fail  out  1  high in FAIL
attempt_cnt  out  4  timeouts in the current calibration run
lost_event  out  1  one-cycle pulse when ready is lost in READY
lost_count  out  8  saturating count of ready-loss events

Behaviour:
- Synchronous reset, active-high: one clock, sys_clk.
- Reset values: state=ASSERT_RST, rst_cnt=0, to_cnt=0, stable_cnt=0, attempt_cnt=0, lost_count=0, idelay_rst=1, cal_busy=1, cal_done=0, cal_fail=0, lost_event=0. Synchroniser flops clear to 0.
- rdy_s is idelay_rdy after SYNC_STAGES flops. All decisions use rdy_s only.
- ASSERT_RST:
  - idelay_rst=1; rst_cnt increments each cycle.
  - After exactly RST_CYCLES cycles in this state (counted from entry, or from the first cycle after sys_rst deasserts), go to WAIT_RDY. Clear to_cnt and stable_cnt.
- WAIT_RDY:
  - idelay_rst=0; to_cnt increments each cycle.
  - stable_cnt increments while rdy_s=1 and clears to 0 when rdy_s=0.
  - When stable_cnt reaches RDY_STABLE, go to READY. Check this first in the cycle.
  - Otherwise, when to_cnt reaches TIMEOUT_CYCLES-1:
    - if attempt_cnt==MAX_RETRIES, go to FAIL;
    - else attempt_cnt+=1 and go to ASSERT_RST.
  - Ready qualifying on the timeout cycle takes priority.
- READY:
  - idelay_rst=0, cal_done=1.
  - rdy_s=0 for any cycle: lost_event=1 that cycle, lost_count+=1 (saturates at 255), attempt_cnt=0, go to ASSERT_RST.
  - start: attempt_cnt=0, go to ASSERT_RST.
  - start and ready-loss in the same cycle cause one restart; lost_count still increments.
- FAIL:
  - idelay_rst=0, cal_fail=1; attempt_cnt holds its final value.
  - start: attempt_cnt=0, go to ASSERT_RST.
  - rdy_s is ignored.
- start is ignored in ASSERT_RST and WAIT_RDY.
- status_clear sets lost_count=0. If it coincides with a loss event, lost_count=1.
- Outputs are registered, so state flags change on the clock after the transition decision.
- sys_rst asserted mid-operation in any state returns everything to reset values on the next edge, including lost_count.
- Counter widths come from $clog2 of their terminal values. No counter wraps: each is cleared on state entry.

Test Plan:
Parameters for all scenarios: RST_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2, RDY_STABLE=4, SYNC_STAGES=2.
1. Release sys_rst; raise idelay_rdy 3 cycles after idelay_rst falls -> idelay_rst high exactly 8 cycles; cal_done rises 2+4 cycles after idelay_rdy rises (plus one register stage); attempt_cnt=0.
2. Hold idelay_rdy=0 -> three reset pulses of 8 cycles, each followed by a 32-cycle wait; attempt_cnt steps 1, 2; then cal_fail=1, attempt_cnt=2, idelay_rst=0. Pulse start -> attempt_cnt=0, new 8-cycle reset pulse.
3. In WAIT_RDY, toggle idelay_rdy high 3 cycles, low 1, high 4 -> no READY after the first burst; READY after the second; stable_cnt restarts from 0 after the glitch.
4. In READY, drop idelay_rdy for 1 cycle, 5 times -> 5 lost_event pulses, lost_count=5, each followed by an 8-cycle reset pulse. status_clear -> lost_count=0. 300 losses -> lost_count=255.
5. In READY, pulse start in the same cycle as a ready loss -> a single reset pulse, lost_count+1. Pulse start during WAIT_RDY -> no effect.
6. Assert sys_rst in the middle of WAIT_RDY with lost_count=3 -> next edge: idelay_rst=1, cal_busy=1, lost_count=0, full sequence restarts.

Source files
------------

// File: rtl/idelay_cal_seq.sv
// IDELAYCTRL calibration sequencer: reset pulse, qualified ready wait with
// timeout/retry, and automatic recalibration on loss of ready.
//
//   state      | meaning
//   ASSERT_RST | idelay_rst held high for RST_CYCLES
//   WAIT_RDY   | waiting for RDY_STABLE consecutive ready cycles, with timeout
//   READY      | calibrated; watching for ready loss or a start request
//   FAIL       | retries exhausted; only start leaves this state
module idelay_cal_seq #(
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRIES    = 3,
  parameter int RDY_STABLE     = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       status_clear,
  input  logic       idelay_rdy,
  output logic       idelay_rst,
  output logic       cal_busy,
  output logic       cal_done,
  output logic       cal_fail,
  output logic [3:0] attempt_cnt,
  output logic       lost_event,
  output logic [7:0] lost_count
);

  localparam logic [1:0] ASSERT_RST = 2'd0;
  localparam logic [1:0] WAIT_RDY   = 2'd1;
  localparam logic [1:0] READY      = 2'd2;
  localparam logic [1:0] FAIL       = 2'd3;

  localparam int RW = $clog2(RST_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = $clog2(RDY_STABLE + 1);

  localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_DONE = SW'(RDY_STABLE);
  localparam logic [3:0]    RETRY_LAST  = 4'(MAX_RETRIES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rdy_s;
  logic [1:0]             state, next_state;
  logic [RW-1:0]          rst_cnt, rst_cnt_n;
  logic [TW-1:0]          to_cnt, to_cnt_n;
  logic [SW-1:0]          stable_cnt, stable_n;
  logic [3:0]             attempt_n;
  logic                   loss;

  assign rdy_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    next_state = state;
    rst_cnt_n  = rst_cnt;
    to_cnt_n   = to_cnt;
    stable_n   = stable_cnt;
    attempt_n  = attempt_cnt;
    loss       = 1'b0;
    case (state)
      ASSERT_RST: begin
        if (rst_cnt == RST_LAST) begin
          next_state = WAIT_RDY;
          to_cnt_n   = '0;
          stable_n   = '0;
        end else begin
          rst_cnt_n = rst_cnt + 1'b1;
        end
      end
      WAIT_RDY: begin
        // a qualified ready wins over a timeout landing on the same cycle
        if (stable_cnt == STABLE_DONE) begin
          next_state = READY;
        end else if (to_cnt == TO_LAST) begin
          rst_cnt_n = '0;
          if (attempt_cnt == RETRY_LAST) begin
            next_state = FAIL;
          end else begin
            attempt_n  = attempt_cnt + 1'b1;
            next_state = ASSERT_RST;
          end
        end else begin
          to_cnt_n = to_cnt + 1'b1;
          stable_n = rdy_s ? stable_cnt + 1'b1 : '0;
        end
      end
      READY: begin
        loss = ~rdy_s;
        if (loss || start) begin
          next_state = ASSERT_RST;
          rst_cnt_n  = '0;
          attempt_n  = '0;
        end
      end
      default: begin
        if (start) begin
          next_state = ASSERT_RST;
          rst_cnt_n  = '0;
          attempt_n  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q      <= '0;
      state       <= ASSERT_RST;
      rst_cnt     <= '0;
      to_cnt      <= '0;
      stable_cnt  <= '0;
      attempt_cnt <= '0;
      lost_count  <= '0;
      idelay_rst  <= 1'b1;
      cal_busy    <= 1'b1;
      cal_done    <= 1'b0;
      cal_fail    <= 1'b0;
      lost_event  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], idelay_rdy};
      state       <= next_state;
      rst_cnt     <= rst_cnt_n;
      to_cnt      <= to_cnt_n;
      stable_cnt  <= stable_n;
      attempt_cnt <= attempt_n;
      // flags decode next_state so they line up with the state register
      idelay_rst  <= (next_state == ASSERT_RST);
      cal_busy    <= (next_state == ASSERT_RST) || (next_state == WAIT_RDY);
      cal_done    <= (next_state == READY);
      cal_fail    <= (next_state == FAIL);
      lost_event  <= loss;
      if (status_clear)
        lost_count <= loss ? 8'd1 : 8'd0;
      else if (loss && lost_count != 8'hFF)
        lost_count <= lost_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_idelay_cal_seq.sv
// Directed bench for idelay_cal_seq with small parameters and
// hand-computed cycle counts.
`timescale 1ns/1ps
module tb_idelay_cal_seq;

  logic       sys_clk = 1'b0;
  logic       sys_rst, start, status_clear, idelay_rdy;
  logic       idelay_rst, cal_busy, cal_done, cal_fail, lost_event;
  logic [3:0] attempt_cnt;
  logic [7:0] lost_count;

  int n_vec = 0;
  int n_err = 0;

  idelay_cal_seq #(
    .RST_CYCLES(8), .TIMEOUT_CYCLES(32), .MAX_RETRIES(2),
    .RDY_STABLE(4), .SYNC_STAGES(2)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .status_clear(status_clear), .idelay_rdy(idelay_rdy),
    .idelay_rst(idelay_rst), .cal_busy(cal_busy), .cal_done(cal_done),
    .cal_fail(cal_fail), .attempt_cnt(attempt_cnt),
    .lost_event(lost_event), .lost_count(lost_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // counts cycles idelay_rst is high starting from the current sample
  task automatic count_rst(output int n, output int ev);
    n = 0;
    ev = 0;
    while (idelay_rst === 1'b1 && n < 100) begin
      n++;
      if (lost_event === 1'b1) ev++;
      tick();
    end
  endtask

  task automatic count_wait(output int n);
    n = 0;
    while (idelay_rst === 1'b0 && cal_fail === 1'b0 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (cal_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_lost(output int n);
    n = 0;
    while (lost_event !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
  endtask

  task automatic drop_rdy();
    idelay_rdy = 1'b0;
    tick();
    idelay_rdy = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, ev, c, bad;
    sys_rst = 1'b1; start = 1'b0; status_clear = 1'b0; idelay_rdy = 1'b0;
    repeat (3) tick();
    chk("rst_idelay_rst", idelay_rst, 1);
    chk("rst_busy", cal_busy, 1);
    chk("rst_done", cal_done, 0);
    chk("rst_fail", cal_fail, 0);
    chk("rst_attempt", attempt_cnt, 0);
    chk("rst_lost_cnt", lost_count, 0);
    chk("rst_lost_ev", lost_event, 0);

    // 1: first calibration, ready 3 cycles after idelay_rst falls
    sys_rst = 1'b0;
    count_rst(n, ev);
    chk("t1_pulse", n, 8);
    repeat (3) tick();
    idelay_rdy = 1'b1;
    wait_done(100, n);
    chk("t1_done_lat", n, 7);
    chk("t1_attempt", attempt_cnt, 0);
    chk("t1_busy", cal_busy, 0);
    chk("t1_idelay_rst", idelay_rst, 0);

    // 2: no ready -> retries then FAIL; start restarts
    sys_rst = 1'b1; idelay_rdy = 1'b0;
    tick();
    sys_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      count_rst(n, ev);
      chk("t2_pulse", n, 8);
      count_wait(n);
      chk("t2_wait", n, 32);
      if (k < 2) chk("t2_attempt", attempt_cnt, k + 1);
    end
    chk("t2_fail", cal_fail, 1);
    chk("t2_fail_attempt", attempt_cnt, 2);
    chk("t2_fail_idelay_rst", idelay_rst, 0);
    chk("t2_fail_busy", cal_busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_restart_attempt", attempt_cnt, 0);
    chk("t2_restart_fail", cal_fail, 0);
    count_rst(n, ev);
    chk("t2_restart_pulse", n, 8);

    // 3: glitch resets the stability counter
    c = 0;
    do begin
      c++;
      idelay_rdy = (c == 4) ? 1'b0 : 1'b1;
      tick();
    end while (cal_done !== 1'b1 && c < 30);
    chk("t3_glitch_lat", c, 11);
    chk("t3_attempt", attempt_cnt, 0);

    // 4: five single-cycle losses
    for (int i = 0; i < 5; i++) begin
      drop_rdy();
      wait_lost(n);
      chk("t4_lost_lat", n, 2);
      chk("t4_lost_cnt", lost_count, i + 1);
      count_rst(n, ev);
      chk("t4_pulse", n, 8);
      chk("t4_ev_width", ev, 1);
      wait_done(40, n);
      chk("t4_recal_lat", n, 5);
    end
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    chk("t4_clear", lost_count, 0);
    chk("t4_clear_done", cal_done, 1);
    idelay_rdy = 1'b0;
    tick();
    idelay_rdy = 1'b1;
    tick();
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    chk("t4_clear_coinc_ev", lost_event, 1);
    chk("t4_clear_coinc", lost_count, 1);
    count_rst(n, ev);
    wait_done(40, n);
    bad = 0;
    for (int j = 0; j < 300; j++) begin
      drop_rdy();
      wait_lost(n);
      if (n != 2) bad++;
      count_rst(n, ev);
      if (n != 8) bad++;
      wait_done(40, n);
      if (n != 5) bad++;
    end
    chk("t4_bulk_bad", bad, 0);
    chk("t4_saturate", lost_count, 255);
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    chk("t4_clear2", lost_count, 0);

    // 5: start coinciding with loss; start ignored in WAIT_RDY
    idelay_rdy = 1'b0;
    tick();
    idelay_rdy = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_lost_ev", lost_event, 1);
    chk("t5_lost_cnt", lost_count, 1);
    chk("t5_idelay_rst", idelay_rst, 1);
    count_rst(n, ev);
    chk("t5_pulse", n, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_wait_idelay_rst", idelay_rst, 0);
    chk("t5_wait_busy", cal_busy, 1);
    wait_done(40, n);
    chk("t5_done_lat", n, 4);
    chk("t5_lost_cnt_hold", lost_count, 1);

    // 6: sys_rst in WAIT_RDY with lost_count=3
    drop_rdy();
    wait_lost(n);
    count_rst(n, ev);
    wait_done(40, n);
    drop_rdy();
    wait_lost(n);
    chk("t6_lost_cnt", lost_count, 3);
    count_rst(n, ev);
    repeat (2) tick();
    chk("t6_in_wait", cal_busy, 1);
    sys_rst = 1'b1;
    tick();
    chk("t6_idelay_rst", idelay_rst, 1);
    chk("t6_busy", cal_busy, 1);
    chk("t6_lost_cnt_clr", lost_count, 0);
    chk("t6_done", cal_done, 0);
    chk("t6_attempt", attempt_cnt, 0);
    sys_rst = 1'b0;
    count_rst(n, ev);
    chk("t6_pulse", n, 8);
    wait_done(40, n);
    chk("t6_done_lat", n, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
